// File: rtl/spi_fifo_core.sv
// spi_fifo_core: MMIO SPI master with W-bit frames, TX/RX FIFOs and optional auto slave-select.
// Define SPI_LOOPBACK_EN to add the ctrl[24] internal mosi->miso loopback path.
module spi_fifo_core #(
    parameter int S      = 2,
    parameter int W      = 8,
    parameter int ADDR_W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic         spi_clk,
    output logic         spi_mosi,
    input  logic         spi_miso,
    output logic [S-1:0] spi_ss_n
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BW    = $clog2(W);

    typedef enum logic [1:0] {IDLE, LEAD, P0, P1} state_t;
    state_t state;

    logic [15:0]  dvsr;
    logic         cpol, cpha, auto_ss, lb;
    logic [3:0]   ss_sel;
    logic [S-1:0] ss_n_reg;

    logic [W-1:0]  tx_mem [DEPTH];
    logic [W-1:0]  rx_mem [DEPTH];
    logic [ADDR_W:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic tx_empty, tx_full, rx_empty, rx_full, overrun;
    logic [W-1:0] tx_head, rx_head;

    logic [15:0]   cnt, dvsr_l;
    logic          cpol_l, cpha_l, hp_done, last_bit, miso_in;
    logic [BW-1:0] bit_cnt;
    logic [W-1:0]  tx_sh, rx_sh;

    logic wr_ss, tx_push_req, wr_ctrl, wr_cmd, rx_pop;
    logic tx_pop, tx_push, rx_push, rx_write;
    logic unused_bits;

    assign wr_ss       = cs && write && addr[2:0] == 3'd1;
    assign tx_push_req = cs && write && addr[2:0] == 3'd2;
    assign wr_ctrl     = cs && write && addr[2:0] == 3'd3;
    assign wr_cmd      = cs && write && addr[2:0] == 3'd4;
    assign rx_pop      = cs && read && addr[2:0] == 3'd0 && !rx_empty;
    assign unused_bits = ^{addr, wr_data};

    assign tx_empty = tx_wp == tx_rp;
    assign tx_full  = (tx_wp[ADDR_W] != tx_rp[ADDR_W]) && (tx_wp[ADDR_W-1:0] == tx_rp[ADDR_W-1:0]);
    assign rx_empty = rx_wp == rx_rp;
    assign rx_full  = (rx_wp[ADDR_W] != rx_rp[ADDR_W]) && (rx_wp[ADDR_W-1:0] == rx_rp[ADDR_W-1:0]);
    assign tx_head  = tx_mem[tx_rp[ADDR_W-1:0]];
    assign rx_head  = rx_mem[rx_rp[ADDR_W-1:0]];

    assign hp_done  = cnt == dvsr_l;
    assign last_bit = bit_cnt == BW'(W - 1);
    assign rx_push  = state == P1 && hp_done && last_bit;
    assign tx_pop   = !tx_empty && (state == IDLE || rx_push);
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign tx_push  = tx_push_req && (!tx_full || tx_pop);
    assign rx_write = rx_push && (!rx_full || rx_pop);

`ifdef SPI_LOOPBACK_EN
    assign miso_in = lb ? spi_mosi : spi_miso;
`else
    assign lb      = 1'b0;
    assign miso_in = spi_miso;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvsr     <= 16'h0200;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
            auto_ss  <= 1'b0;
            ss_sel   <= '0;
            ss_n_reg <= '1;
`ifdef SPI_LOOPBACK_EN
            lb       <= 1'b0;
`endif
        end else begin
            if (wr_ctrl) begin
                dvsr    <= wr_data[15:0];
                cpol    <= wr_data[16];
                cpha    <= wr_data[17];
                auto_ss <= wr_data[18];
                ss_sel  <= wr_data[23:20];
`ifdef SPI_LOOPBACK_EN
                lb      <= wr_data[24];
`endif
            end
            if (wr_ss)
                ss_n_reg <= wr_data[S-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wp[ADDR_W-1:0]] <= wr_data[W-1:0];
        if (rx_write)
            rx_mem[rx_wp[ADDR_W-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wp   <= '0;
            tx_rp   <= '0;
            rx_wp   <= '0;
            rx_rp   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_cmd && wr_data[0]) begin
                tx_wp <= '0;
                tx_rp <= '0;
            end else begin
                if (tx_push) tx_wp <= tx_wp + 1'b1;
                if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            end
            if (wr_cmd && wr_data[1]) begin
                rx_wp <= '0;
                rx_rp <= '0;
            end else begin
                if (rx_write) rx_wp <= rx_wp + 1'b1;
                if (rx_pop)   rx_rp <= rx_rp + 1'b1;
            end
            if (wr_cmd && wr_data[2])
                overrun <= 1'b0;
            else if (rx_push && rx_full && !rx_pop)
                overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            dvsr_l   <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            spi_mosi <= 1'b0;
            spi_clk  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    spi_clk <= cpol;
                    if (!tx_empty) begin
                        tx_sh    <= tx_head;
                        dvsr_l   <= dvsr;
                        cpol_l   <= cpol;
                        cpha_l   <= cpha;
                        spi_mosi <= tx_head[W-1];
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        state    <= LEAD;
                    end
                end
                LEAD: begin
                    if (hp_done) begin
                        cnt     <= '0;
                        spi_clk <= cpol_l ^ cpha_l;
                        state   <= P0;
                    end else
                        cnt <= cnt + 16'd1;
                end
                P0: begin
                    if (hp_done) begin
                        cnt     <= '0;
                        rx_sh   <= {rx_sh[W-2:0], miso_in};
                        spi_clk <= cpol_l ^ ~cpha_l;
                        state   <= P1;
                    end else
                        cnt <= cnt + 16'd1;
                end
                P1: begin
                    if (!hp_done)
                        cnt <= cnt + 16'd1;
                    else begin
                        cnt <= '0;
                        if (!last_bit) begin
                            tx_sh    <= tx_sh << 1;
                            spi_mosi <= tx_sh[W-2];
                            bit_cnt  <= bit_cnt + 1'b1;
                            spi_clk  <= cpol_l ^ cpha_l;
                            state    <= P0;
                        end else if (!tx_empty) begin
                            // Next frame skips LEAD, so its timing/mode is latched here.
                            tx_sh    <= tx_head;
                            dvsr_l   <= dvsr;
                            cpol_l   <= cpol;
                            cpha_l   <= cpha;
                            spi_mosi <= tx_head[W-1];
                            bit_cnt  <= '0;
                            spi_clk  <= cpol ^ cpha;
                            state    <= P0;
                        end else begin
                            spi_clk <= cpol;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        spi_ss_n = '1;
        if (!auto_ss)
            spi_ss_n = ss_n_reg;
        else if (state != IDLE) begin
            for (int unsigned i = 0; i < S; i++)
                if (ss_sel == i[3:0]) spi_ss_n[i] = 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr[2:0])
            3'd0: begin
                rd_data[16]    = rx_empty;
                rd_data[W-1:0] = rx_head;
            end
            3'd1: rd_data[5:0] = {overrun, rx_empty, rx_full, tx_empty, tx_full, state != IDLE};
            3'd3: rd_data = {7'b0, lb, ss_sel, 1'b0, auto_ss, cpha, cpol, dvsr};
            default: rd_data = '0;
        endcase
    end
endmodule
